// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int          WORD_BYTES  = 4;
  localparam int          OFS_W       = $clog2(WORD_BYTES);
  localparam logic [31:0] ERR_RDATA   = 32'h0;
  localparam int          LATENCY_MIN = 1;
  localparam int          LATENCY_MAX = 15;
  localparam int          CNT_W       = $clog2(LATENCY_MAX + 1);

  // Misaligned, or any address bit above the word index is set (no wrap-around).
  function automatic logic addr_err(input logic [31:0] addr, input int addr_w);
    logic err;
    err = (addr[OFS_W-1:0] != '0);
    for (int i = 0; i < 32; i++) begin
      if (i >= addr_w + OFS_W && addr[i]) err = 1'b1;
    end
    return err;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed RAM: synchronous write, asynchronous read.
module dmem_array #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [2**ADDR_W];

  // NOTE: storage arrays carry no reset; clearing every word would force a
  // flop-based implementation instead of a RAM, and contents must survive reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed latency, valid/ready
// on both request and response channels.
import dmem_pkg::*;

module dmem_responder #(
  parameter int ADDR_W  = 6,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam bit               LAT_SHORT = (LATENCY <= LATENCY_MIN);
  localparam logic [CNT_W-1:0] CNT_LOAD  = LAT_SHORT ? '0 : CNT_W'(LATENCY - 2);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept;
  logic              enter_resp;
  logic              svc_we;
  logic [31:0]       svc_addr;
  logic [31:0]       svc_wdata;
  logic              svc_err;
  logic              ram_we;
  logic [31:0]       ram_rdata;

  assign req_ready  = reset && (state_q == IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // With single-cycle latency RESP is entered on the accept edge itself, so the
  // live request must be serviced before it reaches the latches.
  assign svc_we    = (state_q == IDLE) ? req_we    : we_q;
  assign svc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign svc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign svc_err   = addr_err(svc_addr, ADDR_W);

  assign ram_we = reset && enter_resp && svc_we && !svc_err;

  dmem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .waddr (svc_addr[ADDR_W+OFS_W-1:OFS_W]),
    .wdata (svc_wdata),
    .raddr (svc_addr[ADDR_W+OFS_W-1:OFS_W]),
    .rdata (ram_rdata)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LAT_SHORT) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response payload is captured once on RESP entry and held for the handshake.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d   = svc_err;
      rdata_d = (svc_we || svc_err) ? ERR_RDATA : ram_rdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= ERR_RDATA;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: three responders (LATENCY 2, 1, 15) share the
// stimulus bus; `sel` routes handshakes and outputs to one instance at a time.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic [1:0]  sel;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;

  logic        rv_w    [3];
  logic        rr_w    [3];
  logic        rdy_w   [3];
  logic        vld_w   [3];
  logic [31:0] rdata_w [3];
  logic        err_w   [3];

  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int cyc;
  int errors;
  int checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_route
    assign rv_w[g] = req_valid  && (sel == 2'(g));
    assign rr_w[g] = resp_ready && (sel == 2'(g));
  end

  assign req_ready  = rdy_w[sel];
  assign resp_valid = vld_w[sel];
  assign resp_rdata = rdata_w[sel];
  assign resp_err   = err_w[sel];

  dmem_responder #(.ADDR_W(6), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .req_valid(rv_w[0]), .req_ready(rdy_w[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld_w[0]), .resp_ready(rr_w[0]), .resp_rdata(rdata_w[0]), .resp_err(err_w[0])
  );

  dmem_responder #(.ADDR_W(6), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(rv_w[1]), .req_ready(rdy_w[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld_w[1]), .resp_ready(rr_w[1]), .resp_rdata(rdata_w[1]), .resp_err(err_w[1])
  );

  dmem_responder #(.ADDR_W(6), .LATENCY(15)) u_l15 (
    .clk(clk), .reset(reset), .req_valid(rv_w[2]), .req_ready(rdy_w[2]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld_w[2]), .resp_ready(rr_w[2]), .resp_rdata(rdata_w[2]), .resp_err(err_w[2])
  );

  // Presents a request until accepted; returns the acceptance cycle.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output int t);
    bit ok;
    ok = 1'b0;
    t  = cyc;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (req_ready) begin
        t  = cyc;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout addr=%h: req_ready never 1, required 1", addr);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Waits for the response, checks latency/payload, holds it for `hold` cycles, then completes it.
  task automatic wait_resp(input string name, input int t, input int lat,
                           input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s resp_timeout: resp_valid never rose, required within 60 cycles", name);
    end else begin
      checks++;
      if (cyc - t !== lat) begin
        errors++;
        $display("FAIL %s latency: got %0d required %0d", name, cyc - t, lat);
      end
      checks++;
      if (resp_rdata !== exp_rdata) begin
        errors++;
        $display("FAIL %s rdata: got %h required %h", name, resp_rdata, exp_rdata);
      end
      checks++;
      if (resp_err !== exp_err) begin
        errors++;
        $display("FAIL %s err: got %b required %b", name, resp_err, exp_err);
      end
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== exp_rdata || resp_err !== exp_err ||
            req_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s hold%0d: got valid=%b rdata=%h err=%b ready=%b required 1/%h/%b/0",
                   name, h, resp_valid, resp_rdata, resp_err, req_ready, exp_rdata, exp_err);
        end
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s post_handshake: got ready=%b valid=%b required 1/0",
                 name, req_ready, resp_valid);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_cycle_ready inst%0d: got %b required 0", s, req_ready);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 ||
          resp_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle inst%0d: got ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
                 s, req_ready, resp_valid, resp_rdata, resp_err);
      end
    end
    sel = 2'd0;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    int t;
    sel = 2'd0;
    issue(1'b1, 32'h10, 32'hDEADBEEF, t);
    wait_resp("l2_store", t, 2, 32'h0, 1'b0, 0);
    issue(1'b0, 32'h10, 32'h0, t);
    wait_resp("l2_load", t, 2, 32'hDEADBEEF, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    int t;
    sel = 2'd0;
    issue(1'b0, 32'h10, 32'h0, t);
    wait_resp("backpressure", t, 2, 32'hDEADBEEF, 1'b0, 5);
  endtask

  task automatic test_errors();
    int t;
    sel = 2'd0;
    issue(1'b1, 32'h13, 32'hAAAA5555, t);
    wait_resp("misaligned_store", t, 2, 32'h0, 1'b1, 0);
    issue(1'b0, 32'h10, 32'h0, t);
    wait_resp("load_after_err", t, 2, 32'hDEADBEEF, 1'b0, 0);
    issue(1'b0, 32'h100, 32'h0, t);
    wait_resp("oor_load", t, 2, 32'h0, 1'b1, 0);
    issue(1'b0, 32'h80000010, 32'h0, t);
    wait_resp("high_bit_load", t, 2, 32'h0, 1'b1, 0);
    issue(1'b1, 32'hFC, 32'h5555AAAA, t);
    wait_resp("top_word_store", t, 2, 32'h0, 1'b0, 0);
    issue(1'b0, 32'hFC, 32'h0, t);
    wait_resp("top_word_load", t, 2, 32'h5555AAAA, 1'b0, 0);
  endtask

  task automatic test_latency_sweep();
    int t;
    sel = 2'd1;
    issue(1'b1, 32'h40, 32'hCAFEF00D, t);
    wait_resp("l1_store", t, 1, 32'h0, 1'b0, 0);
    issue(1'b0, 32'h40, 32'h0, t);
    wait_resp("l1_load", t, 1, 32'hCAFEF00D, 1'b0, 2);
    issue(1'b0, 32'h102, 32'h0, t);
    wait_resp("l1_err_load", t, 1, 32'h0, 1'b1, 0);
    sel = 2'd2;
    issue(1'b1, 32'h8, 32'h11112222, t);
    wait_resp("l15_store", t, 15, 32'h0, 1'b0, 0);
    issue(1'b0, 32'h8, 32'h0, t);
    wait_resp("l15_load", t, 15, 32'h11112222, 1'b0, 0);
  endtask

  task automatic test_back_to_back(input logic [1:0] s, input int lat);
    int acc[$];
    sel        = s;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h8;
    resp_ready = 1'b1;
    for (int i = 0; i < (lat + 1) * 3; i++) begin
      #1;
      if (req_ready) acc.push_back(cyc);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (lat + 2) @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (acc.size() !== 3) begin
      errors++;
      $display("FAIL b2b_count lat%0d: got %0d accepts required 3", lat, acc.size());
    end else begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (acc[k] - acc[k-1] !== lat + 1) begin
          errors++;
          $display("FAIL b2b_spacing lat%0d: got %0d required %0d", lat, acc[k] - acc[k-1], lat + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int t;
    sel = 2'd0;
    issue(1'b1, 32'h20, 32'h0BADF00D, t);
    wait_resp("pre_store", t, 2, 32'h0, 1'b0, 0);
    issue(1'b1, 32'h20, 32'h12345678, t);
    // Returns in cycle t+1, which the L2 instance spends in WAIT.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_wait_no_resp cycle%0d: got resp_valid=%b required 0", i, resp_valid);
      end
      @(negedge clk);
    end
    issue(1'b0, 32'h20, 32'h0, t);
    wait_resp("mid_wait_old_value", t, 2, 32'h0BADF00D, 1'b0, 0);
  endtask

  initial begin
    cyc        = 0;
    errors     = 0;
    checks     = 0;
    sel        = 2'd0;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_store_load();
    test_backpressure();
    test_errors();
    test_latency_sweep();
    test_back_to_back(2'd1, 1);
    test_back_to_back(2'd0, 2);
    test_back_to_back(2'd2, 15);
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port: accepts one load/store request through a valid/ready handshake.
- Services the request against an internal word-addressed RAM after a fixed, parameterised latency.
- Returns the result through a valid/ready response channel.
- Replaces the zero-latency combinational data memory so that multi-cycle and stalling cores can be exercised against realistic wait states.

Parameters:
- ADDR_W, 6: log2 of memory depth in 32-bit words (default 64 words).
- LATENCY, 2: cycles from request acceptance to first response-valid cycle; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response this cycle.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE; the counter and all request latches clear.
  - req_ready=0 during the reset cycle, 1 from the first cycle after reset is released.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. Acceptance occurs in cycle t when req_valid&req_ready=1. The block latches we/addr/wdata. If LATENCY==1 it goes to RESP; otherwise it loads the counter with LATENCY-2 and goes to WAIT.
  - WAIT: req_ready=0. If counter==0, go to RESP; otherwise decrement.
  - RESP: req_ready=0, resp_valid=1. Stay until resp_ready=1; then go to IDLE.
- Latency and handshake:
  - resp_valid first rises in cycle t+LATENCY.
  - resp_valid, resp_rdata and resp_err stay stable while resp_valid=1 and resp_ready=0.
  - After a response handshake in cycle r, req_ready=1 in cycle r+1. There is never a same-cycle accept and response.
  - Best-case throughput is one request per LATENCY+1 cycles.
  - Only one request is outstanding at a time.
  - resp_ready is ignored outside RESP.
  - req_valid is ignored outside IDLE; the requester must hold the request until it is accepted.
- Address decode:
  - Word index = req_addr[ADDR_W+1:2].
  - Error if req_addr[1:0]!=0, or if any of req_addr[31:ADDR_W+2] is nonzero.
- Store:
  - The RAM write happens at the clock edge on which the FSM enters RESP, and only if there is no error.
  - resp_rdata=0 for a store.
- Load:
  - resp_rdata is captured into a register at the edge entering RESP, so it reflects all prior completed stores.
  - On error: resp_rdata=0 and no RAM access.
- resp_err is registered alongside resp_rdata.
- Reset mid-operation (WAIT or RESP):
  - The transaction is abandoned and the state returns to IDLE.
  - A store that has not yet reached the RESP-entry edge is not written.
- Back-to-back store then load to the same address returns the stored data.
- Writes to word index 2^ADDR_W-1 are legal; anything beyond that index is an error (no wrap-around).

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - Constants WORD_BYTES=4 and ERR_RDATA=32'h0.
  - LATENCY range check constants.
- Sub-module dmem_array:
  - Parameterised by ADDR_W.
  - Synchronous write (we, waddr, wdata) and asynchronous read (raddr -> rdata).
  - No reset.
- The top-level dmem_responder holds the FSM, the counter, the request latches and the error decode.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Store then load, LATENCY=2:
  - Store addr 0x10, data 0xDEADBEEF accepted in cycle t -> resp_valid=1 at t+2, resp_err=0.
  - Then load addr 0x10 -> resp_rdata=0xDEADBEEF exactly 2 cycles after acceptance.
- Response backpressure: hold resp_ready=0 for 5 cycles during a load -> resp_valid, resp_rdata and resp_err stable throughout, req_ready=0; resp_ready=1 -> req_ready=1 on the next cycle.
- Errors:
  - Store to 0x13 -> resp_err=1, resp_rdata=0; a subsequent load of 0x10 returns its unchanged prior value.
  - Load from 0x100 with ADDR_W=6 -> resp_err=1.
- Latency sweep: LATENCY=1 and LATENCY=15 -> resp_valid first rises exactly LATENCY cycles after acceptance. Back-to-back requests are accepted every LATENCY+1 cycles with resp_ready tied to 1.
- Reset mid-WAIT: accept a store to 0x20 of 0x12345678, assert reset in the WAIT cycle -> resp_valid never rises, and a load of 0x20 after reset returns the old value.
